// File: rtl/spi_slave_link.sv
// SPI slave front end: deserialises MOSI frames into opcode+payload words for the
// memory and serialises the memory's read data back out on MISO.
module spi_slave_link #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data
);
    localparam int unsigned RX_W    = DATA_W + 2;
    localparam logic [3:0]  RX_LAST = 4'(RX_W - 1);
    localparam logic [3:0]  RX_DONE = 4'(RX_W);
    localparam logic [3:0]  TX_LAST = 4'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t            r_state;
    logic              r_rd_addr_done;
    logic [3:0]        r_bit_cnt;
    logic [RX_W-2:0]   r_rx_shift;
    logic [DATA_W-1:0] r_tx_shift;
    logic [3:0]        r_tx_cnt;
    logic              r_tx_armed;
    logic              r_tx_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rd_addr_done <= 1'b0;
            r_bit_cnt      <= '0;
            r_rx_shift     <= '0;
            r_tx_shift     <= '0;
            r_tx_cnt       <= '0;
            r_tx_armed     <= 1'b0;
            r_tx_busy      <= 1'b0;
            MISO           <= 1'b0;
            rx_valid       <= 1'b0;
            rx_data        <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (r_state != IDLE && SS_n) begin
                // Abort: drop the partial word and any transfer, keep the read-address flag
                r_state    <= IDLE;
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
                r_tx_shift <= '0;
                r_tx_cnt   <= '0;
                r_tx_armed <= 1'b0;
                r_tx_busy  <= 1'b0;
                MISO       <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!SS_n) begin
                            r_state <= CHK_CMD;
                        end
                    end
                    CHK_CMD: begin
                        r_bit_cnt <= '0;
                        if (!MOSI) begin
                            r_state <= WRITE;
                        end else if (r_rd_addr_done) begin
                            r_state <= READ_DATA;
                        end else begin
                            r_state <= READ_ADD;
                        end
                    end
                    default: begin
                        // Word phase; once complete the state holds and MOSI is ignored
                        if (r_bit_cnt != RX_DONE) begin
                            r_rx_shift <= {r_rx_shift[RX_W-3:0], MOSI};
                            r_bit_cnt  <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == RX_LAST) begin
                                rx_data  <= {r_rx_shift, MOSI};
                                rx_valid <= 1'b1;
                                if (r_state == READ_ADD) begin
                                    r_rd_addr_done <= 1'b1;
                                end
                                if (r_state == READ_DATA) begin
                                    r_rd_addr_done <= 1'b0;
                                    r_tx_armed     <= 1'b1;
                                end
                            end
                        end
                    end
                endcase

                // Transmitter: first tx_valid while armed loads the byte, MSB first
                if (r_tx_busy) begin
                    if (r_tx_cnt == TX_LAST) begin
                        MISO       <= 1'b0;
                        r_tx_busy  <= 1'b0;
                        r_tx_armed <= 1'b0;
                        r_tx_cnt   <= '0;
                    end else begin
                        MISO       <= r_tx_shift[DATA_W-1];
                        r_tx_shift <= r_tx_shift << 1;
                        r_tx_cnt   <= r_tx_cnt + 4'd1;
                    end
                end else if (r_tx_armed && tx_valid) begin
                    MISO       <= tx_data[DATA_W-1];
                    r_tx_shift <= tx_data << 1;
                    r_tx_cnt   <= 4'd1;
                    r_tx_busy  <= 1'b1;
                end
            end
        end
    end

endmodule
